// File: rtl/mem_access_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
// Latency: none (wires only).
// Backpressure: master holds dmem_req and all request fields stable until dmem_ack.
//
// Signals:
//   dmem_req/dmem_we/dmem_addr/dmem_be/dmem_wdata : request, driven by master
//   dmem_ack/dmem_rdata                           : completion, driven by slave
interface mem_access_if #(
   parameter int XLEN = 32
);
   logic            dmem_req;
   logic            dmem_we;
   logic [XLEN-1:0] dmem_addr;
   logic [3:0]      dmem_be;
   logic [XLEN-1:0] dmem_wdata;
   logic            dmem_ack;
   logic [XLEN-1:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      output dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/mem_access.sv
// RISC-V memory-access stage: runs loads/stores on a req/ack bus, registers the MEM/WB boundary.
// Latency: 1 cycle for ALU results; 2+ cycles for loads/stores (op presented -> result registered).
// Backpressure: stall_req holds upstream from op presentation until the cycle dmem_ack arrives.
//
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   rd_in, rd_en_in, rd_addr_in   : EX/MEM result/address, writeback enable, destination register
//   load_flag_in, store_flag_in   : one-hot load {LHU,LBU,LW,LH,LB} / store {SW,SH,SB} selects
//   store_data_in                 : rs2 value for stores
//   stall_req                     : combinational hold request to upstream stages
//   dmem                          : data-memory bus (mem_access_if.master)
//   rd_out, rd_en_out, rd_addr_out: MEM/WB writeback registers
//   misalign_exc, exc_addr        : one-cycle misalignment pulse and faulting address
//   bus_err                       : one-cycle watchdog pulse (only with MEM_TIMEOUT_EN)
//
// Optional feature macro: MEM_TIMEOUT_EN (WAIT-state watchdog and bus_err port).
module mem_access #(
   parameter int XLEN           = 32,
   parameter int REG_AW         = 5,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [XLEN-1:0]   rd_in,
   input  logic              rd_en_in,
   input  logic [REG_AW-1:0] rd_addr_in,
   input  logic [4:0]        load_flag_in,
   input  logic [2:0]        store_flag_in,
   input  logic [XLEN-1:0]   store_data_in,
   output logic              stall_req,
   mem_access_if.master      dmem,
   output logic [XLEN-1:0]   rd_out,
   output logic              rd_en_out,
   output logic [REG_AW-1:0] rd_addr_out,
   output logic              misalign_exc,
   output logic [XLEN-1:0]   exc_addr
`ifdef MEM_TIMEOUT_EN
   ,
   output logic              bus_err
`endif
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   // Access size encoding shared by loads and stores.
   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   if (TIMEOUT_CYCLES < 1) begin : g_timeout_cfg_chk
      $error("mem_access: TIMEOUT_CYCLES must be at least 1");
   end

   logic [0:0] state;

   // Decoded view of the op currently presented by EX/MEM.
   logic            is_load;
   logic            is_store;
   logic            mem_op;
   logic            misaligned;
   logic [1:0]      ld_size;
   logic            ld_sign;
   logic [1:0]      st_size;
   logic [1:0]      acc_size;
   logic [3:0]      acc_be;
   logic [XLEN-1:0] st_wdata;

   // Transaction context captured at issue, used when the ack returns.
   logic              is_load_q;
   logic [1:0]        ld_size_q;
   logic              ld_sign_q;
   logic [1:0]        off_q;
   logic              rd_en_q;
   logic [REG_AW-1:0] rd_addr_q;

   logic [7:0]      lane_b;
   logic [15:0]     lane_h;
   logic [XLEN-1:0] load_val;

`ifdef MEM_TIMEOUT_EN
   function automatic int cnt_width(input int n);
      int w;
      w = $clog2(n + 1);
      if (w < 8)  w = 8;
      if (w > 32) w = 32;
      return w;
   endfunction

   localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] to_cnt;
   logic [XLEN-1:0]  req_addr_q;   // unaligned address, reported on watchdog expiry
   logic             to_hit;

   // Fires in the TIMEOUT_CYCLES-th WAIT cycle; the counter holds 0 in the first one.
   assign to_hit = (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

   // Op decode: any load bit beats any store bit; lowest set bit wins within a group.
   always_comb begin
      is_load  = |load_flag_in;
      is_store = !is_load && (|store_flag_in);
      ld_size  = SZ_B;
      ld_sign  = 1'b0;
      st_size  = SZ_B;
      if (load_flag_in[0]) begin
         ld_size = SZ_B; ld_sign = 1'b1;
      end else if (load_flag_in[1]) begin
         ld_size = SZ_H; ld_sign = 1'b1;
      end else if (load_flag_in[2]) begin
         ld_size = SZ_W; ld_sign = 1'b0;
      end else if (load_flag_in[3]) begin
         ld_size = SZ_B; ld_sign = 1'b0;
      end else if (load_flag_in[4]) begin
         ld_size = SZ_H; ld_sign = 1'b0;
      end
      if (store_flag_in[0])      st_size = SZ_B;
      else if (store_flag_in[1]) st_size = SZ_H;
      else if (store_flag_in[2]) st_size = SZ_W;
      mem_op   = is_load || is_store;
      acc_size = is_load ? ld_size : st_size;
      misaligned = ((acc_size == SZ_H) && rd_in[0]) ||
                   ((acc_size == SZ_W) && (rd_in[1:0] != 2'b00));
   end

   // Stores steer byte enables to the addressed lanes; loads fetch the whole word
   // and select the lane on return, so their enables only encode the access size.
   always_comb begin
      acc_be   = 4'b1111;
      st_wdata = store_data_in;
      case (acc_size)
         SZ_B: begin
            acc_be   = is_store ? (4'b0001 << rd_in[1:0]) : 4'b0001;
            st_wdata = {(XLEN/8){store_data_in[7:0]}};
         end
         SZ_H: begin
            acc_be   = (is_store && rd_in[1]) ? 4'b1100 : 4'b0011;
            st_wdata = {(XLEN/16){store_data_in[15:0]}};
         end
         default: begin
            acc_be   = 4'b1111;
            st_wdata = store_data_in;
         end
      endcase
   end

   // Load lane selection and extension from the latched size/offset.
   always_comb begin
      lane_b = dmem.dmem_rdata[{off_q, 3'b000} +: 8];
      lane_h = off_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
      case (ld_size_q)
         SZ_B:    load_val = {{(XLEN-8){ld_sign_q & lane_b[7]}}, lane_b};
         SZ_H:    load_val = {{(XLEN-16){ld_sign_q & lane_h[15]}}, lane_h};
         default: load_val = dmem.dmem_rdata;
      endcase
   end

   // Hold upstream while an aligned op waits to issue and while WAIT has no ack.
   always_comb begin
      if (state == ST_IDLE) begin
         stall_req = mem_op && !misaligned;
      end else begin
`ifdef MEM_TIMEOUT_EN
         stall_req = !dmem.dmem_ack && !to_hit;
`else
         stall_req = !dmem.dmem_ack;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= ST_IDLE;
         rd_out          <= '0;
         rd_en_out       <= 1'b0;
         rd_addr_out     <= '0;
         misalign_exc    <= 1'b0;
         exc_addr        <= '0;
         dmem.dmem_req   <= 1'b0;
         dmem.dmem_we    <= 1'b0;
         dmem.dmem_addr  <= '0;
         dmem.dmem_be    <= '0;
         dmem.dmem_wdata <= '0;
         is_load_q       <= 1'b0;
         ld_size_q       <= SZ_B;
         ld_sign_q       <= 1'b0;
         off_q           <= 2'b00;
         rd_en_q         <= 1'b0;
         rd_addr_q       <= '0;
`ifdef MEM_TIMEOUT_EN
         to_cnt          <= '0;
         req_addr_q      <= '0;
         bus_err         <= 1'b0;
`endif
      end else begin
         misalign_exc <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         bus_err      <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (!mem_op) begin
                  rd_out      <= rd_in;
                  rd_en_out   <= rd_en_in;
                  rd_addr_out <= rd_addr_in;
               end else if (misaligned) begin
                  // Faulting op retires without touching the bus or the register file.
                  rd_en_out    <= 1'b0;
                  misalign_exc <= 1'b1;
                  exc_addr     <= rd_in;
               end else begin
                  dmem.dmem_req   <= 1'b1;
                  dmem.dmem_we    <= is_store;
                  dmem.dmem_addr  <= {rd_in[XLEN-1:2], 2'b00};
                  dmem.dmem_be    <= acc_be;
                  dmem.dmem_wdata <= is_store ? st_wdata : '0;
                  is_load_q       <= is_load;
                  ld_size_q       <= ld_size;
                  ld_sign_q       <= ld_sign;
                  off_q           <= rd_in[1:0];
                  rd_en_q         <= rd_en_in;
                  rd_addr_q       <= rd_addr_in;
                  rd_en_out       <= 1'b0;
                  state           <= ST_WAIT;
`ifdef MEM_TIMEOUT_EN
                  to_cnt          <= '0;
                  req_addr_q      <= rd_in;
`endif
               end
            end
            ST_WAIT: begin
               if (dmem.dmem_ack) begin
                  dmem.dmem_req <= 1'b0;
                  state         <= ST_IDLE;
                  rd_addr_out   <= rd_addr_q;
                  if (is_load_q) begin
                     rd_out    <= load_val;
                     rd_en_out <= rd_en_q;
                  end else begin
                     rd_en_out <= 1'b0;
                  end
               end
`ifdef MEM_TIMEOUT_EN
               else if (to_hit) begin
                  // Abandon the transaction; the op retires with a bus error.
                  dmem.dmem_req <= 1'b0;
                  rd_en_out     <= 1'b0;
                  bus_err       <= 1'b1;
                  exc_addr      <= req_addr_q;
                  state         <= ST_IDLE;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
`endif
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

   logic        clk;
   logic        rst;
   logic [31:0] rd_in;
   logic        rd_en_in;
   logic [4:0]  rd_addr_in;
   logic [4:0]  load_flag_in;
   logic [2:0]  store_flag_in;
   logic [31:0] store_data_in;
   logic        stall_req;
   logic [31:0] rd_out;
   logic        rd_en_out;
   logic [4:0]  rd_addr_out;
   logic        misalign_exc;
   logic [31:0] exc_addr;
`ifdef MEM_TIMEOUT_EN
   logic        bus_err;
`endif

   mem_access_if #(.XLEN(32)) dm ();

   mem_access #(.XLEN(32), .REG_AW(5), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .rd_in(rd_in), .rd_en_in(rd_en_in), .rd_addr_in(rd_addr_in),
      .load_flag_in(load_flag_in), .store_flag_in(store_flag_in),
      .store_data_in(store_data_in), .stall_req(stall_req),
      .dmem(dm.master),
      .rd_out(rd_out), .rd_en_out(rd_en_out), .rd_addr_out(rd_addr_out),
      .misalign_exc(misalign_exc), .exc_addr(exc_addr)
`ifdef MEM_TIMEOUT_EN
      , .bus_err(bus_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } bus_t;
   typedef struct { logic [31:0] data; logic [4:0] ra; } wb_t;

   bus_t        bus_q[$];
   wb_t         wb_q[$];
   logic [31:0] exc_q[$];

   // kind: 0 = no memory op, 1 = load, 2 = store
   function automatic void model_decode(input logic [4:0] lf, input logic [2:0] sf,
                                        output int kind, output int nbytes, output bit sgn);
      kind = 0; nbytes = 0; sgn = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (lf[i] && kind == 0) begin
            kind = 1;
            nbytes = (i == 2) ? 4 : ((i == 1 || i == 4) ? 2 : 1);
            sgn = (i < 2);
         end
      end
      for (int i = 0; i < 3; i++) begin
         if (sf[i] && kind == 0) begin
            kind = 2;
            nbytes = 1 << i;
         end
      end
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                              input int nbytes, input bit sgn);
      logic [31:0] v, mask, top;
      if (nbytes == 4) return rdata;
      v    = rdata >> (8 * (addr % 4));
      mask = (nbytes == 1) ? 32'hFF : 32'hFFFF;
      top  = (nbytes == 1) ? 32'h80 : 32'h8000;
      v    = v & mask;
      if (sgn && ((v & top) != 0)) v = v | ~mask;
      return v;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [31:0] sd, input int nbytes);
      if (nbytes == 1) return (sd & 32'hFF) * 32'h0101_0101;
      if (nbytes == 2) return (sd & 32'hFFFF) * 32'h0001_0001;
      return sd;
   endfunction

   // ---------------- compare process ----------------
   logic        seen_we;
   logic [31:0] seen_addr;
   logic [3:0]  seen_be;
   logic [31:0] seen_wdata;

   always @(negedge clk) begin
      if (!rst) begin
         if (dm.dmem_req) begin
            seen_we = dm.dmem_we; seen_addr = dm.dmem_addr;
            seen_be = dm.dmem_be; seen_wdata = dm.dmem_wdata;
            if (bus_q.size() == 0) begin
               chk("unexpected_req", 1, 0);
            end else begin
               chk("bus_we",   dm.dmem_we,   bus_q[0].we);
               chk("bus_addr", dm.dmem_addr, bus_q[0].addr);
               chk("bus_be",   dm.dmem_be,   bus_q[0].be);
               if (bus_q[0].we) chk("bus_wdata", dm.dmem_wdata, bus_q[0].wdata);
               if (dm.dmem_ack) void'(bus_q.pop_front());
            end
         end
         if (rd_en_out) begin
            if (wb_q.size() == 0) begin
               chk("unexpected_writeback", 1, 0);
            end else begin
               chk("wb_data", rd_out, wb_q[0].data);
               chk("wb_addr", rd_addr_out, wb_q[0].ra);
               void'(wb_q.pop_front());
            end
         end
         if (misalign_exc) begin
            if (exc_q.size() == 0) begin
               chk("unexpected_misalign", 1, 0);
            end else begin
               chk("misalign_addr", exc_addr, exc_q[0]);
               void'(exc_q.pop_front());
            end
         end
`ifdef MEM_TIMEOUT_EN
         if (bus_err && bus_q.size() > 0) void'(bus_q.pop_front());
`endif
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      rd_in = '0; rd_en_in = 1'b0; rd_addr_in = '0;
      load_flag_in = '0; store_flag_in = '0; store_data_in = '0;
   endtask

   // Presents one op, answers the bus after wait_n WAIT cycles, returns 1 ns after the
   // completing edge with upstream idle.
   task automatic run_op(input logic [31:0] addr, input logic en, input logic [4:0] ra,
                         input logic [4:0] lf, input logic [2:0] sf, input logic [31:0] sd,
                         input int wait_n, input logic [31:0] rdata);
      int kind, nb; bit sgn; bit mis;
      bus_t b;
      model_decode(lf, sf, kind, nb, sgn);
      mis = (kind != 0) && ((addr % nb) != 0);
      rd_in = addr; rd_en_in = en; rd_addr_in = ra;
      load_flag_in = lf; store_flag_in = sf; store_data_in = sd;
      if (kind == 0) begin
         if (en) wb_q.push_back('{data: addr, ra: ra});
      end else if (mis) begin
         exc_q.push_back(addr);
      end else begin
         b.we    = (kind == 2);
         b.addr  = addr & 32'hFFFF_FFFC;
         b.be    = (kind == 2) ? 4'(((1 << nb) - 1) << (addr % 4)) : 4'((1 << nb) - 1);
         b.wdata = model_wdata(sd, nb);
         bus_q.push_back(b);
         if (kind == 1 && en) wb_q.push_back('{data: model_load(rdata, addr, nb, sgn), ra: ra});
      end
      @(negedge clk);
      if (kind == 0 || mis) begin
         chk("stall_nomem", stall_req, 0);
         chk("no_req", dm.dmem_req, 0);
         step();
      end else begin
         chk("stall_issue", stall_req, 1);
         step();
         for (int w = 0; w < wait_n; w++) begin
            @(negedge clk);
            chk("stall_wait", stall_req, 1);
            chk("req_held", dm.dmem_req, 1);
            step();
         end
         dm.dmem_ack = 1'b1; dm.dmem_rdata = rdata;
         @(negedge clk);
         chk("stall_ack", stall_req, 0);
         step();
         dm.dmem_ack = 1'b0; dm.dmem_rdata = '0;
      end
      drive_idle();
   endtask

   typedef struct {
      logic [31:0] addr; logic en; logic [4:0] ra; logic [4:0] lf; logic [2:0] sf;
      logic [31:0] sd; int wait_n; logic [31:0] rdata;
      logic [31:0] exp_rd; logic [3:0] exp_be; logic [31:0] exp_wd;
   } vec_t;

   vec_t vecs[16] = '{
      '{32'h0000_1234, 1, 5'd5,  5'b00000, 3'b000, 32'h0,         0, 32'h0,         32'h0000_1234, 4'h0, 32'h0},
      '{32'h0000_1003, 1, 5'd6,  5'b00001, 3'b000, 32'h0,         0, 32'h80FF_FF7F, 32'hFFFF_FF80, 4'b0001, 32'h0},
      '{32'h0000_2002, 1, 5'd7,  5'b10000, 3'b000, 32'h0,         3, 32'hBEEF_1234, 32'h0000_BEEF, 4'b0011, 32'h0},
      '{32'h0000_3002, 1, 5'd1,  5'b00000, 3'b010, 32'h0000_ABCD, 1, 32'h0,         32'h0,         4'b1100, 32'hABCD_ABCD},
      '{32'h0000_4001, 1, 5'd2,  5'b00100, 3'b000, 32'h0,         0, 32'h0,         32'h0,         4'h0, 32'h0},
      '{32'h0000_0100, 1, 5'd8,  5'b00100, 3'b000, 32'h0,         2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111, 32'h0},
      '{32'h0000_0102, 1, 5'd9,  5'b00010, 3'b000, 32'h0,         0, 32'h8001_0000, 32'hFFFF_8001, 4'b0011, 32'h0},
      '{32'h0000_0101, 1, 5'd10, 5'b01000, 3'b000, 32'h0,         1, 32'h0000_9A00, 32'h0000_009A, 4'b0001, 32'h0},
      '{32'h0000_0203, 1, 5'd3,  5'b00000, 3'b001, 32'h1234_5655, 0, 32'h0,         32'h0,         4'b1000, 32'h5555_5555},
      '{32'h0000_0204, 1, 5'd3,  5'b00000, 3'b100, 32'hCAFE_F00D, 2, 32'h0,         32'h0,         4'b1111, 32'hCAFE_F00D},
      '{32'h0000_0300, 1, 5'd11, 5'b00100, 3'b100, 32'h5555_AAAA, 0, 32'h1122_3344, 32'h1122_3344, 4'b1111, 32'h0},
      '{32'h0000_0306, 1, 5'd12, 5'b00110, 3'b000, 32'h0,         0, 32'h7FFF_0000, 32'h0000_7FFF, 4'b0011, 32'h0},
      '{32'h0000_0301, 1, 5'd13, 5'b00000, 3'b010, 32'h0000_1111, 0, 32'h0,         32'h0,         4'h0, 32'h0},
      '{32'h0000_0400, 0, 5'd14, 5'b00001, 3'b000, 32'h0,         0, 32'h0000_00FF, 32'h0,         4'b0001, 32'h0},
      '{32'hFFFF_FFFF, 1, 5'd31, 5'b00000, 3'b000, 32'h0,         0, 32'h0,         32'hFFFF_FFFF, 4'h0, 32'h0},
      '{32'h0000_0502, 1, 5'd15, 5'b00000, 3'b110, 32'h0000_BEEF, 1, 32'h0,         32'h0,         4'b1100, 32'hBEEF_BEEF}
   };

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int kind, nb; bit sgn;
      rst = 1'b1;
      drive_idle();
      dm.dmem_ack = 1'b0; dm.dmem_rdata = '0;
      #3;
      chk("rst_rd_out", rd_out, 0);
      chk("rst_rd_en_out", rd_en_out, 0);
      chk("rst_rd_addr_out", rd_addr_out, 0);
      chk("rst_req", dm.dmem_req, 0);
      chk("rst_we", dm.dmem_we, 0);
      chk("rst_addr", dm.dmem_addr, 0);
      chk("rst_be", dm.dmem_be, 0);
      chk("rst_wdata", dm.dmem_wdata, 0);
      chk("rst_misalign", misalign_exc, 0);
      chk("rst_exc_addr", exc_addr, 0);
      chk("rst_stall", stall_req, 0);
      @(negedge clk);
      rst = 1'b0;
      step();

      foreach (vecs[i]) begin
         model_decode(vecs[i].lf, vecs[i].sf, kind, nb, sgn);
         run_op(vecs[i].addr, vecs[i].en, vecs[i].ra, vecs[i].lf, vecs[i].sf,
                vecs[i].sd, vecs[i].wait_n, vecs[i].rdata);
         @(negedge clk);
         if (kind != 0 && (vecs[i].addr % nb) != 0) begin
            chk("lit_misalign_pulse", misalign_exc, 1);
            chk("lit_exc_addr", exc_addr, vecs[i].addr);
            chk("lit_misalign_rd_en", rd_en_out, 0);
            step();
            @(negedge clk);
            chk("lit_misalign_one_cycle", misalign_exc, 0);
         end else if (kind == 0) begin
            chk("lit_alu_rd_en", rd_en_out, vecs[i].en);
            chk("lit_alu_rd_out", rd_out, vecs[i].exp_rd);
            chk("lit_alu_rd_addr", rd_addr_out, vecs[i].ra);
         end else begin
            chk("lit_be", seen_be, vecs[i].exp_be);
            chk("lit_addr", seen_addr, vecs[i].addr & 32'hFFFF_FFFC);
            chk("lit_we", seen_we, kind == 2);
            chk("lit_req_dropped", dm.dmem_req, 0);
            if (kind == 2) begin
               chk("lit_wdata", seen_wdata, vecs[i].exp_wd);
               chk("lit_store_rd_en", rd_en_out, 0);
            end else begin
               chk("lit_load_rd_en", rd_en_out, vecs[i].en);
               if (vecs[i].en) chk("lit_load_rd_out", rd_out, vecs[i].exp_rd);
               step();
               @(negedge clk);
               chk("lit_load_rd_en_once", rd_en_out, 0);
            end
         end
         step();
      end

      // Reset while a load is outstanding, then a stray ack.
      rd_in = 32'h0000_5000; rd_en_in = 1'b1; rd_addr_in = 5'd3; load_flag_in = 5'b00100;
      bus_q.push_back('{we: 1'b0, addr: 32'h0000_5000, be: 4'b1111, wdata: 32'h0});
      @(negedge clk);
      chk("rstw_stall_issue", stall_req, 1);
      step();
      @(negedge clk);
      chk("rstw_req_up", dm.dmem_req, 1);
      #2;
      rst = 1'b1;
      drive_idle();
      bus_q.delete();
      #1;
      chk("rstw_req", dm.dmem_req, 0);
      chk("rstw_addr", dm.dmem_addr, 0);
      chk("rstw_be", dm.dmem_be, 0);
      chk("rstw_rd_en", rd_en_out, 0);
      chk("rstw_rd_out", rd_out, 0);
      chk("rstw_stall", stall_req, 0);
      @(negedge clk);
      rst = 1'b0;
      step();
      dm.dmem_ack = 1'b1; dm.dmem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("idle_ack_no_req", dm.dmem_req, 0);
      chk("idle_ack_stall", stall_req, 0);
      step();
      dm.dmem_ack = 1'b0;
      @(negedge clk);
      chk("idle_ack_no_wb", rd_en_out, 0);
      step();

`ifdef MEM_TIMEOUT_EN
      rd_in = 32'h0000_6000; rd_en_in = 1'b1; rd_addr_in = 5'd4; load_flag_in = 5'b00100;
      bus_q.push_back('{we: 1'b0, addr: 32'h0000_6000, be: 4'b1111, wdata: 32'h0});
      @(negedge clk);
      chk("to_stall_issue", stall_req, 1);
      step();
      for (int w = 1; w <= 4; w++) begin
         @(negedge clk);
         chk("to_req_held", dm.dmem_req, 1);
         chk("to_no_err_yet", bus_err, 0);
         chk("to_stall", stall_req, (w < 4));
         step();
      end
      drive_idle();
      @(negedge clk);
      chk("to_bus_err", bus_err, 1);
      chk("to_exc_addr", exc_addr, 32'h0000_6000);
      chk("to_req_dropped", dm.dmem_req, 0);
      chk("to_rd_en", rd_en_out, 0);
      step();
      @(negedge clk);
      chk("to_bus_err_once", bus_err, 0);
      step();
`endif

      chk("bus_q_drained", bus_q.size(), 0);
      chk("wb_q_drained", wb_q.size(), 0);
      chk("exc_q_drained", exc_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
